// File: rtl/gumnut_alu_sequencer_pkg.sv
// Shared definitions for the Gumnut ALU sequencer: opcode prefixes, IR field
// positions, FSM states and the instruction-class decoder.
package gumnut_alu_sequencer_pkg;

  localparam int unsigned IR_W   = 18;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;

  localparam logic [2:0] OP_SHIFT = 3'b110;
  localparam logic [3:0] OP_REG   = 4'b1110;

  localparam int unsigned RD_LSB = 11;
  localparam int unsigned RS_LSB = 8;
  localparam int unsigned R2_LSB = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CLS_IMM,
    CLS_SHIFT,
    CLS_REG,
    CLS_ILLEGAL
  } instr_class_e;

  function automatic instr_class_e classify(input logic [IR_W-1:0] ir);
    if (!ir[17])                   return CLS_IMM;
    else if (ir[17:15] == OP_SHIFT) return CLS_SHIFT;
    else if (ir[17:14] == OP_REG)   return CLS_REG;
    else                            return CLS_ILLEGAL;
  endfunction

  function automatic logic [ADDR_W-1:0] rd_of(input logic [IR_W-1:0] ir);
    return ir[RD_LSB +: ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] rs_of(input logic [IR_W-1:0] ir);
    return ir[RS_LSB +: ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] r2_of(input logic [IR_W-1:0] ir);
    return ir[R2_LSB +: ADDR_W];
  endfunction

endpackage

// File: rtl/gumnut_regfile.sv
// 8x8 general-purpose register file: two combinational read ports, one
// synchronous write port, r0 hardwired to zero. GUMNUT_SEQ_DBG_EN adds a debug read port.
module gumnut_regfile
  import gumnut_alu_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  input  logic [ADDR_W-1:0] rb_addr_i,
  output logic [DATA_W-1:0] rb_data_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i
`ifdef GUMNUT_SEQ_DBG_EN
  ,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
`endif
);

  logic [DATA_W-1:0] regs_q [8];

  // NOTE: the storage is cleared by reset because a mid-instruction reset must
  // leave every register reading zero; this forces flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign ra_data_o = (ra_addr_i == '0) ? '0 : regs_q[ra_addr_i];
  assign rb_data_o = (rb_addr_i == '0) ? '0 : regs_q[rb_addr_i];

`ifdef GUMNUT_SEQ_DBG_EN
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];
`endif

endmodule

// File: rtl/gumnut_alu_sequencer.sv
// Multicycle sequencer driving an external Gumnut ALU: IDLE -> READ -> EXEC -> WB.
// Optional GUMNUT_SEQ_DBG_EN adds a combinational register readback port.
module gumnut_alu_sequencer
  import gumnut_alu_sequencer_pkg::*;
#(
  parameter int unsigned EXEC_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [17:0] instr,
  output logic [7:0]  GPR_rs,
  output logic [7:0]  GPR_r2,
  output logic [17:0] IR,
  input  logic [7:0]  ALU_result,
  input  logic [7:0]  ALU_shift_result,
  output logic        done,
  output logic        illegal,
  output logic [7:0]  wb_data,
  output logic        zero_flag
`ifdef GUMNUT_SEQ_DBG_EN
  ,
  input  logic [2:0]  dbg_addr,
  output logic [7:0]  dbg_data
`endif
);

  localparam logic [2:0] WAIT_CNT = 3'(EXEC_WAIT);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0] rs_q, rs_d;
  logic [DATA_W-1:0] r2_q, r2_d;
  logic [DATA_W-1:0] wb_q, wb_d;
  logic              z_q, z_d;

  logic [DATA_W-1:0] rf_a_data, rf_b_data;
  instr_class_e      cls;
  logic              rf_we;

  assign cls   = classify(ir_q);
  assign rf_we = (state_q == ST_WB) && (cls != CLS_ILLEGAL);

  gumnut_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_addr_i (rs_of(ir_q)),
    .ra_data_o (rf_a_data),
    .rb_addr_i (r2_of(ir_q)),
    .rb_data_o (rf_b_data),
    .we_i      (rf_we),
    .wa_i      (rd_of(ir_q)),
    .wd_i      (wb_q)
`ifdef GUMNUT_SEQ_DBG_EN
    ,
    .dbg_addr_i(dbg_addr),
    .dbg_data_o(dbg_data)
`endif
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ir_q    <= '0;
      rs_q    <= '0;
      r2_q    <= '0;
      wb_q    <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      rs_q    <= rs_d;
      r2_q    <= r2_d;
      wb_q    <= wb_d;
      z_q     <= z_d;
    end
  end

  // NOTE: every next-state variable is defaulted to its current value first,
  // so no path through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    rs_d    = rs_q;
    r2_d    = r2_q;
    wb_d    = wb_q;
    z_d     = z_q;

    unique case (state_q)
      ST_IDLE: begin
        // The word is captured at the accept edge, so later instr changes are ignored.
        if (instr_valid) begin
          ir_d    = instr;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        rs_d    = rf_a_data;
        r2_d    = (cls == CLS_REG) ? rf_b_data : '0;
        cnt_d   = WAIT_CNT;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          wb_d    = (cls == CLS_SHIFT) ? ALU_shift_result : ALU_result;
          state_d = ST_WB;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_WB: begin
        if (cls != CLS_ILLEGAL) z_d = (wb_q == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign done        = (state_q == ST_WB);
  assign illegal     = (state_q == ST_WB) && (cls == CLS_ILLEGAL);
  assign GPR_rs      = rs_q;
  assign GPR_r2      = r2_q;
  assign IR          = ir_q;
  assign wb_data     = wb_q;
  assign zero_flag   = z_q;

endmodule
